// File: rtl/flag_unit_if.sv
// Bus bundle between the ALU stage / decoder and the flag unit.
// The master drives operands and control, and the slave returns the registered flags.
interface flag_unit_if #(
   parameter int WIDTH = 16
);
   logic [1:0]       op_class;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             psr_load;
   logic [4:0]       psr_in;
   logic             save;
   logic             restore;
   logic [4:0]       flags;
   logic             shadow_valid;
   logic             restore_err;

   modport master (
      output op_class, a, b, psr_load, psr_in, save, restore,
      input  flags, shadow_valid, restore_err
   );

   modport slave (
      input  op_class, a, b, psr_load, psr_in, save, restore,
      output flags, shadow_valid, restore_err
   );
endinterface

// File: rtl/flag_unit.sv
// Condition-flag register: computes C/L/F/Z/N from ALU/compare operands.
// Also supports PSR load and a one-deep interrupt shadow.
module flag_unit #(
   parameter int WIDTH = 16
) (
   input  logic      clock,
   input  logic      reset,
   flag_unit_if.slave bus
);
   localparam int MSB = WIDTH - 1;

   localparam int C_BIT = 0;
   localparam int L_BIT = 1;
   localparam int F_BIT = 2;
   localparam int Z_BIT = 3;
   localparam int N_BIT = 4;

   logic [4:0]       flags_q, flags_d;
   logic [4:0]       shadow_q, shadow_d;
   logic             shadowValid_q, shadowValid_d;
   logic             restoreErr_q, restoreErr_d;

   logic [WIDTH-1:0] sumW;
   logic [WIDTH-1:0] diffW;
   logic             restoreValid;
   logic [4:0]       computed;

   assign sumW         = bus.b + bus.a;
   assign diffW        = bus.b - bus.a;
   assign restoreValid = bus.restore && shadowValid_q;

   // Each class rewrites only its own flags and passes the rest through.
   // ADD carry-out is detected as the wrapped sum falling below an operand.
   always_comb begin
      computed = flags_q;
      unique case (bus.op_class)
         2'b01: begin
            computed[C_BIT] = (sumW < bus.b);
            computed[F_BIT] = (bus.a[MSB] == bus.b[MSB]) && (sumW[MSB] != bus.b[MSB]);
         end
         2'b10: begin
            computed[C_BIT] = (bus.b < bus.a);
            computed[F_BIT] = (bus.a[MSB] != bus.b[MSB]) && (diffW[MSB] != bus.b[MSB]);
         end
         2'b11: begin
            computed[Z_BIT] = (diffW == '0);
            computed[L_BIT] = (bus.b < bus.a);
            computed[N_BIT] = ($signed(bus.b) < $signed(bus.a));
         end
         default: computed = flags_q;
      endcase
   end

   // A valid restore outranks psr_load, which outranks the computed update.
   // The shadow always captures the pre-edge flags, so save+restore is a swap.
   always_comb begin
      flags_d       = flags_q;
      shadow_d      = shadow_q;
      shadowValid_d = shadowValid_q;
      restoreErr_d  = restoreErr_q;

      if (restoreValid) begin
         flags_d = shadow_q;
      end else if (bus.psr_load) begin
         flags_d = bus.psr_in;
      end else begin
         flags_d = computed;
      end

      if (bus.save) begin
         shadow_d      = flags_q;
         shadowValid_d = 1'b1;
      end else if (restoreValid) begin
         shadowValid_d = 1'b0;
      end

      if (bus.restore && !shadowValid_q) begin
         restoreErr_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         flags_q       <= 5'b00000;
         shadow_q      <= 5'b00000;
         shadowValid_q <= 1'b0;
         restoreErr_q  <= 1'b0;
      end else begin
         flags_q       <= flags_d;
         shadow_q      <= shadow_d;
         shadowValid_q <= shadowValid_d;
         restoreErr_q  <= restoreErr_d;
      end
   end

   assign bus.flags        = flags_q;
   assign bus.shadow_valid = shadowValid_q;
   assign bus.restore_err  = restoreErr_q;
endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: one task per scenario, with hand-computed flag values.
module tb_flag_unit;
   logic clock;
   logic reset;
   int   checks;
   int   failures;

   flag_unit_if #(.WIDTH(16)) bus ();

   flag_unit #(.WIDTH(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle before the caller samples outputs.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idleInputs();
      bus.op_class = 2'b00;
      bus.a        = 16'h0000;
      bus.b        = 16'h0000;
      bus.psr_load = 1'b0;
      bus.psr_in   = 5'b00000;
      bus.save     = 1'b0;
      bus.restore  = 1'b0;
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idleInputs();
      pulseReset();
      repeat (3) step();
      checks++;
      if (bus.flags !== 5'b00000) begin
         failures++;
         $display("[TB] FAIL reset_flags got %b want %b", bus.flags, 5'b00000);
      end
      checks++;
      if (bus.shadow_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_shadow_valid got %b want 0", bus.shadow_valid);
      end
      checks++;
      if (bus.restore_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_restore_err got %b want 0", bus.restore_err);
      end
   endtask

   task automatic test_add();
      bus.op_class = 2'b01; bus.a = 16'hFFFF; bus.b = 16'h0001;
      step();
      checks++;
      if (bus.flags !== 5'b00001) begin
         failures++;
         $display("[TB] FAIL add_carry got %b want %b", bus.flags, 5'b00001);
      end
      bus.a = 16'h7FFF; bus.b = 16'h0001;
      step();
      checks++;
      if (bus.flags !== 5'b00100) begin
         failures++;
         $display("[TB] FAIL add_overflow got %b want %b", bus.flags, 5'b00100);
      end
      bus.op_class = 2'b00; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
      step();
      checks++;
      if (bus.flags !== 5'b00100) begin
         failures++;
         $display("[TB] FAIL idle_hold got %b want %b", bus.flags, 5'b00100);
      end
   endtask

   task automatic test_cmp();
      idleInputs();
      pulseReset();
      bus.op_class = 2'b11; bus.a = 16'h0001; bus.b = 16'hFFFF;
      step();
      checks++;
      if (bus.flags !== 5'b10000) begin
         failures++;
         $display("[TB] FAIL cmp_signed_less got %b want %b", bus.flags, 5'b10000);
      end
      bus.a = 16'h1234; bus.b = 16'h1234;
      step();
      checks++;
      if (bus.flags !== 5'b01000) begin
         failures++;
         $display("[TB] FAIL cmp_equal got %b want %b", bus.flags, 5'b01000);
      end
      bus.a = 16'hFFFF; bus.b = 16'h0001;
      step();
      checks++;
      if (bus.flags !== 5'b00010) begin
         failures++;
         $display("[TB] FAIL cmp_unsigned_less got %b want %b", bus.flags, 5'b00010);
      end
   endtask

   task automatic test_sub_psr();
      bus.op_class = 2'b11; bus.a = 16'h1234; bus.b = 16'h1234;
      step();
      bus.op_class = 2'b10; bus.a = 16'h0005; bus.b = 16'h0003;
      step();
      checks++;
      if (bus.flags !== 5'b01001) begin
         failures++;
         $display("[TB] FAIL sub_borrow got %b want %b", bus.flags, 5'b01001);
      end
      bus.a = 16'h0001; bus.b = 16'h8000;
      step();
      checks++;
      if (bus.flags !== 5'b01100) begin
         failures++;
         $display("[TB] FAIL sub_overflow got %b want %b", bus.flags, 5'b01100);
      end
      bus.a = 16'h0005; bus.b = 16'h0003;
      bus.psr_load = 1'b1; bus.psr_in = 5'b01010;
      step();
      checks++;
      if (bus.flags !== 5'b01010) begin
         failures++;
         $display("[TB] FAIL psr_over_sub got %b want %b", bus.flags, 5'b01010);
      end
      idleInputs();
   endtask

   task automatic test_save_restore();
      bus.save = 1'b1; bus.op_class = 2'b11; bus.a = 16'h0055; bus.b = 16'h0055;
      step();
      idleInputs();
      checks++;
      if (bus.flags !== 5'b01000 || bus.shadow_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL save_cmp got flags=%b sv=%b want flags=01000 sv=1", bus.flags, bus.shadow_valid);
      end
      bus.restore = 1'b1;
      step();
      checks++;
      if (bus.flags !== 5'b01010 || bus.shadow_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL restore got flags=%b sv=%b want flags=01010 sv=0", bus.flags, bus.shadow_valid);
      end
      step();
      bus.restore = 1'b0;
      checks++;
      if (bus.flags !== 5'b01010 || bus.restore_err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL restore_empty got flags=%b err=%b want flags=01010 err=1", bus.flags, bus.restore_err);
      end
      bus.op_class = 2'b01; bus.a = 16'hFFFF; bus.b = 16'h0001;
      step();
      idleInputs();
      checks++;
      if (bus.flags !== 5'b01011 || bus.restore_err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL err_sticky got flags=%b err=%b want flags=01011 err=1", bus.flags, bus.restore_err);
      end
   endtask

   task automatic test_swap();
      idleInputs();
      pulseReset();
      bus.psr_load = 1'b1; bus.psr_in = 5'b00001;
      step();
      bus.psr_load = 1'b0; bus.save = 1'b1;
      step();
      bus.save = 1'b0; bus.psr_load = 1'b1; bus.psr_in = 5'b10000;
      step();
      bus.psr_load = 1'b0; bus.save = 1'b1; bus.restore = 1'b1;
      step();
      bus.save = 1'b0; bus.restore = 1'b0;
      checks++;
      if (bus.flags !== 5'b00001 || bus.shadow_valid !== 1'b1 || bus.restore_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL swap got flags=%b sv=%b err=%b want 00001 1 0", bus.flags, bus.shadow_valid, bus.restore_err);
      end
      bus.restore = 1'b1; bus.psr_load = 1'b1; bus.psr_in = 5'b11111;
      step();
      idleInputs();
      checks++;
      if (bus.flags !== 5'b10000 || bus.shadow_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL restore_over_psr got flags=%b sv=%b want 10000 0", bus.flags, bus.shadow_valid);
      end
   endtask

   task automatic test_reset_mid();
      bus.save = 1'b1;
      step();
      bus.save = 1'b0; bus.restore = 1'b1;
      step();
      step();
      bus.restore = 1'b0;
      bus.save = 1'b1; bus.psr_load = 1'b1; bus.psr_in = 5'b11111;
      bus.op_class = 2'b01; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
      reset = 1'b1;
      step();
      reset = 1'b0;
      idleInputs();
      checks++;
      if (bus.flags !== 5'b00000 || bus.shadow_valid !== 1'b0 || bus.restore_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mid got flags=%b sv=%b err=%b want 00000 0 0", bus.flags, bus.shadow_valid, bus.restore_err);
      end
      bus.restore = 1'b1;
      step();
      idleInputs();
      checks++;
      if (bus.flags !== 5'b00000 || bus.restore_err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL shadow_cleared got flags=%b err=%b want 00000 1", bus.flags, bus.restore_err);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      idleInputs();
      test_reset();
      test_add();
      test_cmp();
      test_sub_psr();
      test_save_restore();
      test_swap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
